// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch state encoding, reset/bubble constants and
// word-alignment helper used by the fetch stage.
package pipeline_pkg;

  localparam int          WORD_BYTES = 4;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// feeds IF/ID, holding a word across stalls and inserting a bubble on redirect.
module fetch_unit
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ifid_en,
  output logic [31:0] instr_out,
  output logic [31:0] pc4_out
);

  fetch_state_t state, state_next;

  logic [31:0] pc;
  logic [31:0] addr_q;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc4;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        take_redirect;
  logic        buf_load;

  assign pc_plus4      = pc + 32'(WORD_BYTES);
  assign target        = word_align(redirect_pc);
  assign take_redirect = redirect && (state != ST_IDLE);
  assign buf_load      = (state == ST_REQ) && imem_ack && stall && !redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  state_next = ST_REQ;
      ST_REQ: begin
        if (redirect) begin
          // An unacked request cannot be withdrawn, so its data must be drained.
          state_next = imem_ack ? ST_REQ : ST_DRAIN;
        end else if (imem_ack && stall) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD:  if (redirect || !stall) state_next = ST_REQ;
      ST_DRAIN: if (imem_ack) state_next = ST_REQ;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      addr_q    <= RESET_PC;
      buf_instr <= '0;
      buf_pc4   <= '0;
    end else begin
      if (take_redirect) begin
        pc <= target;
      end else if ((state == ST_REQ) && imem_ack) begin
        pc <= pc_plus4;
      end
      if (state == ST_REQ) begin
        addr_q <= pc;
      end
      if (buf_load) begin
        buf_instr <= imem_rdata;
        buf_pc4   <= pc_plus4;
      end
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    ifid_en   = 1'b0;
    instr_out = '0;
    pc4_out   = '0;
    case (state)
      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_ack && !stall) begin
          ifid_en   = 1'b1;
          instr_out = imem_rdata;
          pc4_out   = pc_plus4;
        end
      end
      ST_HOLD: begin
        ifid_en   = !stall;
        instr_out = buf_instr;
        pc4_out   = buf_pc4;
      end
      ST_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = addr_q;
      end
      default: ;
    endcase
    // The bubble overrides whatever the state would otherwise deliver.
    if (take_redirect) begin
      ifid_en   = 1'b1;
      instr_out = NOP_WORD;
      pc4_out   = '0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level model plus directed
// scenarios with hand-computed expectations.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ifid_en;
  logic [31:0] instr_out;
  logic [31:0] pc4_out;

  int total_cnt = 0;
  int pass_cnt  = 0;
  bit mon_en    = 0;
  int lat       = 0;
  int wait_cnt;

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ifid_en    (ifid_en),
    .instr_out  (instr_out),
    .pc4_out    (pc4_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: acks after `lat` wait cycles, data = address ^ A5A5_0000.
  assign imem_ack   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = imem_ack ? (imem_addr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // Model: started flag, next pc, an optional held word, an optional orphan request.
  bit          m_started;
  logic [31:0] m_pc;
  bit          m_held_v;
  logic [31:0] m_held_instr, m_held_pc4;
  bit          m_orph_v;
  logic [31:0] m_orph_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started <= 0;
      m_pc      <= 32'h0000_3000;
      m_held_v  <= 0;
      m_orph_v  <= 0;
    end else if (!m_started) begin
      m_started <= 1;
    end else if (m_orph_v) begin
      if (imem_ack) m_orph_v <= 0;
      if (redirect) m_pc <= {redirect_pc[31:2], 2'b00};
    end else if (m_held_v) begin
      if (redirect) begin
        m_held_v <= 0;
        m_pc     <= {redirect_pc[31:2], 2'b00};
      end else if (!stall) begin
        m_held_v <= 0;
      end
    end else begin
      if (redirect) begin
        if (!imem_ack) begin
          m_orph_v    <= 1;
          m_orph_addr <= m_pc;
        end
        m_pc <= {redirect_pc[31:2], 2'b00};
      end else if (imem_ack) begin
        if (stall) begin
          m_held_v     <= 1;
          m_held_instr <= imem_rdata;
          m_held_pc4   <= m_pc + 32'd4;
        end
        m_pc <= m_pc + 32'd4;
      end
    end
  end

  logic        e_req, e_en, e_cmp_data;
  logic [31:0] e_addr, e_instr, e_pc4;

  always_comb begin
    e_req      = 1'b0;
    e_addr     = 32'h0000_3000;
    e_en       = 1'b0;
    e_instr    = 32'h0;
    e_pc4      = 32'h0;
    e_cmp_data = 1'b1;
    if (!m_started) begin
      e_cmp_data = 1'b1;
    end else if (m_orph_v) begin
      e_req      = 1'b1;
      e_addr     = m_orph_addr;
      e_en       = redirect;
      e_cmp_data = redirect;
    end else if (m_held_v) begin
      e_en    = redirect || !stall;
      e_instr = redirect ? 32'h0 : m_held_instr;
      e_pc4   = redirect ? 32'h0 : m_held_pc4;
    end else begin
      e_req  = 1'b1;
      e_addr = m_pc;
      if (redirect) begin
        e_en = 1'b1;
      end else if (imem_ack && !stall) begin
        e_en    = 1'b1;
        e_instr = imem_rdata;
        e_pc4   = m_pc + 32'd4;
      end
      e_cmp_data = e_en;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("mdl_req", {31'b0, imem_req}, {31'b0, e_req});
      check("mdl_en", {31'b0, ifid_en}, {31'b0, e_en});
      if (e_req) check("mdl_addr", imem_addr, e_addr);
      if (e_cmp_data) begin
        check("mdl_instr", instr_out, e_instr);
        check("mdl_pc4", pc4_out, e_pc4);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    // Reset values and zero-wait streaming
    lat = 0;
    reset_dut();
    mon_en = 1;
    @(negedge clk);
    check("idle_en", {31'b0, ifid_en}, 32'd0);
    check("idle_addr", imem_addr, 32'h0000_3000);
    cyc(); @(negedge clk);
    check("s1_instr", instr_out, 32'hA5A5_3000);
    check("s1_pc4", pc4_out, 32'h0000_3004);
    cyc(); @(negedge clk);
    check("s2_pc4", pc4_out, 32'h0000_3008);
    cyc(); @(negedge clk);
    check("s3_pc4", pc4_out, 32'h0000_300C);
    check("s3_en", {31'b0, ifid_en}, 32'd1);

    // Stall captured into hold for 3 cycles
    reset_dut();
    cyc();
    cyc(); stall = 1'b1; @(negedge clk);
    check("st_ack_en", {31'b0, ifid_en}, 32'd0);
    check("st_ack_addr", imem_addr, 32'h0000_3004);
    cyc(); @(negedge clk);
    check("st_hold_req", {31'b0, imem_req}, 32'd0);
    check("st_hold_instr", instr_out, 32'hA5A5_3004);
    cyc(); @(negedge clk);
    check("st_hold_en", {31'b0, ifid_en}, 32'd0);
    cyc(); stall = 1'b0; @(negedge clk);
    check("st_rel_en", {31'b0, ifid_en}, 32'd1);
    check("st_rel_pc4", pc4_out, 32'h0000_3008);
    cyc(); @(negedge clk);
    check("st_next_addr", imem_addr, 32'h0000_3008);

    // Redirect with ack: bubble then aligned target
    reset_dut();
    cyc(); redirect = 1'b1; redirect_pc = 32'h0000_4002; @(negedge clk);
    check("rd_en", {31'b0, ifid_en}, 32'd1);
    check("rd_instr", instr_out, 32'h0);
    check("rd_pc4", pc4_out, 32'h0);
    cyc(); redirect = 1'b0; @(negedge clk);
    check("rd_tgt_addr", imem_addr, 32'h0000_4000);
    check("rd_tgt_pc4", pc4_out, 32'h0000_4004);

    // Redirect during a wait cycle: drain old address first
    lat = 2;
    reset_dut();
    cyc(); redirect = 1'b1; redirect_pc = 32'h0000_5000; @(negedge clk);
    check("dr_bubble", {31'b0, ifid_en}, 32'd1);
    cyc(); redirect = 1'b0; @(negedge clk);
    check("dr_addr", imem_addr, 32'h0000_3000);
    check("dr_en", {31'b0, ifid_en}, 32'd0);
    cyc(); @(negedge clk);
    check("dr_ack_en", {31'b0, ifid_en}, 32'd0);
    check("dr_ack_addr", imem_addr, 32'h0000_3000);
    cyc(); @(negedge clk);
    check("dr_new_addr", imem_addr, 32'h0000_5000);

    // PC wrap
    lat = 0;
    reset_dut();
    cyc(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc(); redirect = 1'b0; @(negedge clk);
    check("wrap_pc4", pc4_out, 32'h0);
    check("wrap_en", {31'b0, ifid_en}, 32'd1);
    cyc(); @(negedge clk);
    check("wrap_addr", imem_addr, 32'h0);

    // Asynchronous reset in DRAIN
    lat = 2;
    reset_dut();
    cyc(); redirect = 1'b1; redirect_pc = 32'h0000_6000;
    cyc(); redirect = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_req", {31'b0, imem_req}, 32'd0);
    check("ar_addr", imem_addr, 32'h0000_3000);
    check("ar_en", {31'b0, ifid_en}, 32'd0);
    check("ar_pc4", pc4_out, 32'h0);
    cyc(); rst_n = 1'b1;
    cyc(); @(negedge clk);
    check("ar_restart", imem_addr, 32'h0000_3000);
    check("ar_restart_req", {31'b0, imem_req}, 32'd1);

    // Mixed stall/redirect patterns at several latencies
    for (int seg = 0; seg < 3; seg++) begin
      lat = seg;
      reset_dut();
      for (int i = 0; i < 40; i++) begin
        stall       = ((i % 5) == 2) || ((i % 7) == 3);
        redirect    = ((i % 11) == 6);
        redirect_pc = 32'h0000_8000 + 32'(i * 16) + 32'(i & 3);
        cyc();
      end
      stall = 1'b0; redirect = 1'b0;
    end

    @(negedge clk);
    mon_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
